// File: rtl/mult_div_unit_if.sv
// Operand, MTHI/MTLO and HI/LO result bundle of the EX-stage multiply/divide unit.
// The pipeline side drives through master; the unit itself attaches to slave.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Each operation takes WIDTH+1 cycles: WIDTH shift iterations, then one sign fix-up cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] rs_raw_q;
    logic             sign_q;
    logic             sign_r;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             start_signed;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0] quot_fixed;
    logic [WIDTH-1:0] rem_fixed;
    logic             last_iter;

    assign start_signed = ~bus.op[0];
    assign rs_mag = (start_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    assign rt_mag = (start_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
    assign last_iter = (count == CW'(WIDTH - 1));

    // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; bit WIDTH of the trial difference is its borrow.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    assign prod_fixed = sign_q ? -acc : acc;
    assign quot_fixed = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fixed  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = CALC;
            CALC: if (last_iter) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            rs_raw_q <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            acc      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        count    <= '0;
                        rs_raw_q <= bus.rs_data;
                        sign_q   <= start_signed & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                        sign_r   <= start_signed & bus.rs_data[WIDTH-1];
                        // Multiplier or dividend shifts through the low half; the other operand stays put.
                        acc      <= {{WIDTH{1'b0}}, bus.op[1] ? rs_mag : rt_mag};
                        mcand_q  <= bus.op[1] ? rt_mag : rs_mag;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    acc   <= op_q[1] ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (!op_q[1]) begin
                        hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fixed[WIDTH-1:0];
                    end else if (mcand_q == '0) begin
                        hi_q <= rs_raw_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fixed;
                        lo_q <= quot_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] mh = '0;
    logic [31:0] ml = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                eh = sp[63:32];
                el = sp[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            default: begin
                if (b == 0) begin
                    eh = a;
                    el = '1;
                end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = '0;
                    el = 32'h8000_0000;
                end else if (o == 2'b10) begin
                    el = sa / sb;
                    eh = sa % sb;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    // Drive start for the edge following the current negedge; returns on the next negedge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.rs_data = a;
        bus.rt_data = b;
        @(negedge clk);
        bus.start = 1'b0;
        check("done_not_consecutive", {63'b0, bus.done}, 64'd0);
    endtask

    task automatic wait_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                               input int already);
        int busy_cnt;
        bit seen;
        busy_cnt = already;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, "_hi"}, {32'b0, bus.hi}, {32'b0, eh});
        check({tag, "_lo"}, {32'b0, bus.lo}, {32'b0, el});
        mh = eh;
        ml = el;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] eh, el;
        model(o, a, b, eh, el);
        issue(o, a, b);
        wait_result(tag, eh, el, 0);
    endtask

    initial begin
        logic [31:0] eh, el, ra, rb;
        logic [1:0]  ro;
        int          done_hits;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.rs_data = '0; bus.rt_data = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_hi",   {32'b0, bus.hi}, 64'd0);
        check("reset_lo",   {32'b0, bus.lo}, 64'd0);
        check("reset_busy", {63'b0, bus.busy}, 64'd0);
        check("reset_done", {63'b0, bus.done}, 64'd0);

        // Directed cases, issued back to back.
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi_const", {32'b0, bus.hi}, 64'h0000_0000_FFFF_FFFE);
        run_op("mult_neg",   2'b00, 32'hFFFF_FFFD, 32'd7);
        run_op("div_neg",    2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero",  2'b11, 32'd100, 32'd0);
        run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero_s", 2'b10, 32'hFFFF_FF00, 32'd0);

        // Reset in the middle of a MULT discards it.
        @(negedge clk);
        issue(2'b00, 32'd1234, 32'd5678);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_busy", {63'b0, bus.busy}, 64'd0);
        check("midreset_hi",   {32'b0, bus.hi}, 64'd0);
        check("midreset_lo",   {32'b0, bus.lo}, 64'd0);
        check("midreset_done", {63'b0, bus.done}, 64'd0);
        done_hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_hits++;
        end
        check("midreset_no_done", 64'(done_hits), 64'd0);
        mh = '0;
        ml = '0;

        // A start while busy is ignored.
        issue(2'b11, 32'd9, 32'd4);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd3; bus.rt_data = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_result("start_busy", 32'd1, 32'd2, 5);

        // MTLO while busy is dropped.
        model(2'b00, 32'd11, 32'hFFFF_FFFF, eh, el);
        issue(2'b00, 32'd11, 32'hFFFF_FFFF);
        bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("lowe_busy_lo", {32'b0, bus.lo}, {32'b0, ml});
        wait_result("lowe_busy", eh, el, 1);

        // MTHI in idle, then MTHI and MTLO together.
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_hi", {32'b0, bus.hi}, 64'h1234_5678);
        check("mthi_lo", {32'b0, bus.lo}, {32'b0, ml});
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mthilo_hi", {32'b0, bus.hi}, 64'h0BAD_F00D);
        check("mthilo_lo", {32'b0, bus.lo}, 64'h0BAD_F00D);

        // MTHI together with start: the write is dropped.
        bus.hi_we = 1'b1; bus.wdata = 32'hCAFE_F00D;
        issue(2'b11, 32'd9, 32'd4);
        bus.hi_we = 1'b0;
        check("mthi_start_hi", {32'b0, bus.hi}, 64'h0BAD_F00D);
        wait_result("mthi_start", 32'd1, 32'd2, 0);

        // Random back-to-back operations.
        for (int k = 0; k < 24; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", k, ro), ro, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
